// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_unit
// Purpose  : Fetch/decode/execute sequencer for the 8-bit computer. Sole
//            master of the 16x8 RAM; holds PC, IR, A, B, output register and
//            a small ALU. Moves words between the input port, RAM and the
//            output register.
// Options  : CPU_SINGLE_STEP_EN - adds a step_i input and a STEP_WAIT state
//            that gates every instruction fetch (and start) on step_i.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
`ifdef CPU_SINGLE_STEP_EN
  input  logic              step_i,
`endif
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_strobe_o,
  output logic [DATA_W-1:0] reg_a_o,
  output logic [DATA_W-1:0] reg_b_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o
);

  localparam int OP_W = DATA_W - ADDR_W;
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  localparam logic [OP_W-1:0] OP_LDA  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LDB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LDO  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_STA  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_STB  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_STI  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_INC  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_DEC  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_STOP = OP_W'(15);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_MEM_RD    = 3'd3;
  localparam logic [2:0] S_MEM_WR    = 3'd4;
  localparam logic [2:0] S_WAIT_IN   = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;
`ifdef CPU_SINGLE_STEP_EN
  localparam logic [2:0] S_STEP_WAIT = 3'd7;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q, a_q, b_q, out_q, in_q;
  logic              strobe_q;

  logic [OP_W-1:0]   op_w;
  logic [ADDR_W-1:0] opnd_w;
  logic [DATA_W-1:0] alu_w;
  logic              go_w;
  logic [2:0]        resume_w;

  assign op_w   = ir_q[DATA_W-1:ADDR_W];
  assign opnd_w = ir_q[ADDR_W-1:0];

`ifdef CPU_SINGLE_STEP_EN
  // A finished instruction only proceeds to the next fetch on a step cycle.
  assign go_w     = start_i & step_i;
  assign resume_w = step_i ? S_FETCH : S_STEP_WAIT;
`else
  assign go_w     = start_i;
  assign resume_w = S_FETCH;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decision, including opcode dispatch out of DECODE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (go_w) state_d = S_FETCH;
      S_FETCH:        state_d = S_DECODE;
      S_DECODE: begin
        case (op_w)
          OP_LDA, OP_LDB, OP_LDO: state_d = S_MEM_RD;
          OP_STA, OP_STB:         state_d = S_MEM_WR;
          OP_STI:                 state_d = S_WAIT_IN;
          OP_STOP:                state_d = S_HALT;
          default:                state_d = resume_w;
        endcase
      end
      S_MEM_RD:       state_d = resume_w;
      S_MEM_WR:       state_d = resume_w;
      S_WAIT_IN:      if (in_valid_i) state_d = S_MEM_WR;
`ifdef CPU_SINGLE_STEP_EN
      S_STEP_WAIT:    if (step_i) state_d = S_FETCH;
`endif
      default:        state_d = S_IDLE;
    endcase
  end

  // Moore outputs; enables decode from the state register so reset kills them at once.
  always_comb begin
    mem_addr_o  = '0;
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_wdata_o = '0;
    in_ready_o  = 1'b0;
    halted_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_addr_o  = pc_q;
        mem_rd_en_o = 1'b1;
      end
      S_MEM_RD: begin
        mem_addr_o  = opnd_w;
        mem_rd_en_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_addr_o  = opnd_w;
        mem_wr_en_o = 1'b1;
        if (op_w == OP_STA)      mem_wdata_o = a_q;
        else if (op_w == OP_STB) mem_wdata_o = b_q;
        else                     mem_wdata_o = in_q;
      end
      S_WAIT_IN: in_ready_o = 1'b1;
      S_HALT:    halted_o   = 1'b1;
      default: ;
    endcase
  end

  // ALU result for register-only opcodes; wraps modulo 2^DATA_W.
  always_comb begin
    alu_w = a_q;
    case (op_w)
      OP_ADD: alu_w = a_q + b_q;
      OP_SUB: alu_w = a_q - b_q;
      OP_INC: alu_w = a_q + DATA_W'(1);
      OP_DEC: alu_w = a_q - DATA_W'(1);
      OP_AND: alu_w = a_q & b_q;
      OP_OR:  alu_w = a_q | b_q;
      OP_XOR: alu_w = a_q ^ b_q;
      OP_NOT: alu_w = ~a_q;
      default: ;
    endcase
  end

  // Datapath registers: PC, IR, A, B, output register, input latch and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_RST;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      in_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= (state_q == S_MEM_RD) && (op_w == OP_LDO);
      case (state_q)
        S_IDLE, S_HALT: if (go_w) pc_q <= PC_RST;
        S_FETCH: begin
          ir_q <= mem_rdata_i;
          pc_q <= pc_q + ADDR_W'(1);
        end
        S_DECODE: begin
          if (op_w == OP_JMP) pc_q <= opnd_w;
          a_q <= alu_w;
        end
        S_MEM_RD: begin
          if (op_w == OP_LDA)      a_q   <= mem_rdata_i;
          else if (op_w == OP_LDB) b_q   <= mem_rdata_i;
          else                     out_q <= mem_rdata_i;
        end
        S_WAIT_IN: if (in_valid_i) in_q <= in_data_i;
        default: ;
      endcase
    end
  end

  assign out_data_o   = out_q;
  assign out_strobe_o = strobe_q;
  assign reg_a_o      = a_q;
  assign reg_b_o      = b_q;
  assign pc_o         = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control_unit
// Purpose  : Self-checking bench for cpu_control_unit with a RAM model and an
//            instruction-level reference interpreter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [3:0] mem_addr_o;
  logic       mem_rd_en_o, mem_wr_en_o;
  logic [7:0] mem_wdata_o, mem_rdata_i;
  logic [7:0] in_data_i;
  logic       in_valid_i, in_ready_o;
  logic [7:0] out_data_o;
  logic       out_strobe_o;
  logic [7:0] reg_a_o, reg_b_o;
  logic [3:0] pc_o;
  logic       halted_o;
`ifdef CPU_SINGLE_STEP_EN
  logic       step_i;
`endif

  always #5 clk = ~clk;

  cpu_control_unit #(.ADDR_W(4), .DATA_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
`ifdef CPU_SINGLE_STEP_EN
    .step_i(step_i),
`endif
    .mem_addr_o(mem_addr_o), .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_strobe_o(out_strobe_o),
    .reg_a_o(reg_a_o), .reg_b_o(reg_b_o), .pc_o(pc_o), .halted_o(halted_o)
  );

  // RAM model: combinational read, synchronous write, bulk preload on load_req.
  logic [7:0] ram [16];
  logic [7:0] pre [16];
  logic       load_req = 1'b0;
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 16; i++) ram[i] <= pre[i];
    end else if (mem_wr_en_o) begin
      ram[mem_addr_o] <= mem_wdata_o;
    end
  end
  assign mem_rdata_i = ram[mem_addr_o];

  int n_cmp  = 0;
  int n_fail = 0;
  int excl_bad = 0;
  logic [7:0] strobe_q [$];

  // Reference machine state.
  logic [7:0] m_mem [16];
  logic [7:0] m_a, m_b, m_out;
  int         m_cyc;
  logic [7:0] m_str [$];

  // One clock: sample just after the edge, log strobes and enable overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_strobe_o) strobe_q.push_back(out_data_o);
    if (mem_rd_en_o && mem_wr_en_o) excl_bad++;
  endtask

  task automatic load_ram();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    strobe_q.delete();
  endtask

  task automatic clear_pre();
    for (int i = 0; i < 16; i++) pre[i] = 8'h00;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_a = 8'h00; m_b = 8'h00; m_out = 8'h00;
  endtask

  // Start from IDLE/HALT and count cycles until HALT is visible.
  task automatic run_dut(output int cyc);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!halted_o && cyc < 500);
  endtask

  // Instruction-level interpreter with the architectural cycle cost of each class.
  task automatic model_run();
    int pc;
    logic [7:0] ir;
    logic [3:0] op, a;
    pc = 0; m_cyc = 0; m_str.delete();
    for (int s = 0; s < 64; s++) begin
      ir = m_mem[pc];
      pc = (pc + 1) % 16;
      op = ir[7:4]; a = ir[3:0];
      if (op <= 4'd4) m_cyc += 3; else m_cyc += 2;
      case (op)
        4'd0:  m_a = m_mem[a];
        4'd1:  m_b = m_mem[a];
        4'd2:  begin m_out = m_mem[a]; m_str.push_back(m_out); end
        4'd3:  m_mem[a] = m_a;
        4'd4:  m_mem[a] = m_b;
        4'd6:  m_a = m_a + m_b;
        4'd7:  m_a = m_a - m_b;
        4'd8:  m_a = m_a + 8'd1;
        4'd9:  m_a = m_a - 8'd1;
        4'd10: m_a = m_a & m_b;
        4'd11: m_a = m_a | m_b;
        4'd12: m_a = m_a ^ m_b;
        4'd13: m_a = ~m_a;
        4'd14: pc = int'(a);
        default: ;
      endcase
      if (op == 4'd15) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b1; in_valid_i = 1'b0; in_data_i = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o, in_ready_o, out_data_o,
           out_strobe_o, reg_a_o, reg_b_o, pc_o, halted_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: addr=%h rd=%b wr=%b wd=%h rdy=%b out=%h stb=%b a=%h b=%h pc=%h hlt=%b, required all zero",
                 c, mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o, in_ready_o, out_data_o,
                 out_strobe_o, reg_a_o, reg_b_o, pc_o, halted_o);
      end
    end
    start_i = 1'b0;
    rst_n = 1'b1;
    m_a = 8'h00; m_b = 8'h00; m_out = 8'h00;
    tick();
    n_cmp++;
    if (mem_rd_en_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset rd_en=%b required 0", mem_rd_en_o);
    end
  endtask

  task automatic test_program();
    int cyc;
    clear_pre();
    pre[0] = 8'h0F; pre[1] = 8'h1E; pre[2] = 8'h6F; pre[3] = 8'h3B; pre[4] = 8'hFF;
    pre[15] = 8'h03; pre[14] = 8'h01;
    load_ram();
    run_dut(cyc);
    n_cmp++; if (reg_a_o !== 8'h04) begin n_fail++; $display("FAIL prog_a got %h required 04", reg_a_o); end
    n_cmp++; if (ram[11] !== 8'h04) begin n_fail++; $display("FAIL prog_ram11 got %h required 04", ram[11]); end
    n_cmp++; if (cyc != 13) begin n_fail++; $display("FAIL prog_cycles got %0d required 13", cyc); end
    n_cmp++; if (halted_o !== 1'b1) begin n_fail++; $display("FAIL prog_halted got %b required 1", halted_o); end
    m_a = 8'h04; m_b = 8'h01;
  endtask

  task automatic test_alu_wrap();
    int cyc;
    clear_pre();
    pre[0] = 8'h0F; pre[1] = 8'h80; pre[2] = 8'hFF; pre[15] = 8'hFF;
    load_ram();
    run_dut(cyc);
    n_cmp++; if (reg_a_o !== 8'h00) begin n_fail++; $display("FAIL inc_wrap got %h required 00", reg_a_o); end
    n_cmp++; if (cyc != 7) begin n_fail++; $display("FAIL inc_wrap_cycles got %0d required 7", cyc); end
    clear_pre();
    pre[0] = 8'h0F; pre[1] = 8'h1E; pre[2] = 8'h70; pre[3] = 8'hFF;
    pre[15] = 8'h00; pre[14] = 8'h01;
    load_ram();
    run_dut(cyc);
    n_cmp++; if (reg_a_o !== 8'hFF) begin n_fail++; $display("FAIL sub_wrap got %h required FF", reg_a_o); end
    m_a = 8'hFF; m_b = 8'h01;
  endtask

  task automatic test_jump_wrap();
    logic [3:0] fa [6];
    logic [3:0] exp_fa [6];
    logic [3:0] pc_after15;
    logic [7:0] a0;
    int n, cyc;
    bit saw15, got;
    exp_fa = '{4'd0, 4'd7, 4'd15, 4'd0, 4'd7, 4'd15};
    clear_pre();
    pre[0] = 8'hE7; pre[7] = 8'hEF; pre[15] = 8'h80;
    load_ram();
    a0 = reg_a_o;
    start_i = 1'b1; tick(); start_i = 1'b0;
    n = 0; cyc = 0; saw15 = 0; got = 0; pc_after15 = 4'hX;
    while (n < 6 && cyc < 60) begin
      if (saw15 && !got) begin pc_after15 = pc_o; got = 1; end
      if (mem_rd_en_o) begin
        fa[n] = mem_addr_o;
        if (mem_addr_o == 4'd15) saw15 = 1;
        n++;
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (n != 6) begin n_fail++; $display("FAIL jump_fetch_count got %0d required 6", n); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i < n && fa[i] !== exp_fa[i]) begin
        n_fail++; $display("FAIL jump_fetch_addr[%0d] got %0d required %0d", i, fa[i], exp_fa[i]);
      end
    end
    n_cmp++;
    if (pc_after15 !== 4'd0) begin n_fail++; $display("FAIL pc_wrap got %h required 0", pc_after15); end
    n_cmp++;
    if (reg_a_o !== a0 + 8'd1) begin n_fail++; $display("FAIL jump_loop_a got %h required %h", reg_a_o, a0 + 8'd1); end
    reset_pulse();
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    clear_pre();
    pre[0] = 8'h3A; pre[10] = 8'h55;
    load_ram();
    start_i = 1'b1; tick(); start_i = 1'b0;
    cyc = 0;
    while (!mem_wr_en_o && cyc < 10) begin tick(); cyc++; end
    n_cmp++;
    if (mem_wr_en_o !== 1'b1) begin n_fail++; $display("FAIL reach_mem_wr got wr_en=%b required 1", mem_wr_en_o); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_wr_en_o !== 1'b0 || pc_o !== 4'd0 || halted_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got wr=%b pc=%h hlt=%b required 0/0/0", mem_wr_en_o, pc_o, halted_o);
    end
    tick();
    rst_n = 1'b1;
    m_a = 8'h00; m_b = 8'h00; m_out = 8'h00;
    tick();
    n_cmp++;
    if (ram[10] !== 8'h55) begin n_fail++; $display("FAIL aborted_write got %h required 55", ram[10]); end
    n_cmp++;
    if (mem_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL idle_after_async got rd=%b required 0", mem_rd_en_o); end
  endtask

  task automatic test_input_loop();
    int rdy_cnt, cyc;
    logic [7:0] exp_v;
    clear_pre();
    pre[0] = 8'h5F; pre[1] = 8'h0F; pre[2] = 8'h8F; pre[3] = 8'h3F; pre[4] = 8'h2F; pre[5] = 8'hE2;
    load_ram();
    in_valid_i = 1'b0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    rdy_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      if (in_ready_o) rdy_cnt++;
      if (c == 7) begin in_valid_i = 1'b1; in_data_i = 8'h05; end
      else tick();
    end
    n_cmp++;
    if (rdy_cnt != 5) begin n_fail++; $display("FAIL in_ready_wait got %0d cycles required 5", rdy_cnt); end
    tick();
    in_valid_i = 1'b0;
    n_cmp++;
    if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL in_ready_drop got %b required 0", in_ready_o); end
    cyc = 0;
    while (strobe_q.size() < 3 && cyc < 100) begin tick(); cyc++; end
    n_cmp++;
    if (strobe_q.size() < 3) begin n_fail++; $display("FAIL strobe_count got %0d required 3", strobe_q.size()); end
    exp_v = 8'h06;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i < strobe_q.size() && strobe_q[i] !== exp_v) begin
        n_fail++; $display("FAIL loop_out[%0d] got %h required %h", i, strobe_q[i], exp_v);
      end
      exp_v = exp_v + 8'd1;
    end
    reset_pulse();
  endtask

  task automatic test_random();
    int ops [13];
    int n, cyc;
    ops = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13};
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 16; i++) pre[i] = 8'($urandom);
      n = int'($urandom_range(3, 9));
      for (int i = 0; i < n; i++)
        pre[i] = {4'(ops[$urandom_range(0, 12)]), 4'($urandom_range(10, 15))};
      pre[n] = 8'hFF;
      for (int i = 0; i < 16; i++) m_mem[i] = pre[i];
      model_run();
      load_ram();
      run_dut(cyc);
      n_cmp++;
      if (cyc != m_cyc) begin n_fail++; $display("FAIL rnd%0d cycles got %0d required %0d", it, cyc, m_cyc); end
      n_cmp++;
      if (reg_a_o !== m_a || reg_b_o !== m_b) begin
        n_fail++; $display("FAIL rnd%0d regs got a=%h b=%h required a=%h b=%h", it, reg_a_o, reg_b_o, m_a, m_b);
      end
      n_cmp++;
      if (out_data_o !== m_out) begin n_fail++; $display("FAIL rnd%0d out got %h required %h", it, out_data_o, m_out); end
      n_cmp++;
      if (strobe_q.size() != m_str.size() || strobe_q != m_str) begin
        n_fail++; $display("FAIL rnd%0d strobes got %0d values required %0d", it, strobe_q.size(), m_str.size());
      end
      for (int i = 10; i < 16; i++) begin
        n_cmp++;
        if (ram[i] !== m_mem[i]) begin n_fail++; $display("FAIL rnd%0d ram[%0d] got %h required %h", it, i, ram[i], m_mem[i]); end
      end
    end
    n_cmp++;
    if (excl_bad != 0) begin n_fail++; $display("FAIL rd_wr_overlap got %0d cycles required 0", excl_bad); end
  endtask

`ifdef CPU_SINGLE_STEP_EN
  task automatic test_single_step();
    clear_pre();
    pre[0] = 8'h80; pre[1] = 8'h80; pre[2] = 8'hFF;
    load_ram();
    step_i = 1'b1; start_i = 1'b1; tick(); step_i = 1'b0; start_i = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (reg_a_o !== 8'h01 || mem_rd_en_o !== 1'b0) begin
      n_fail++; $display("FAIL step_hold got a=%h rd=%b required 01/0", reg_a_o, mem_rd_en_o);
    end
    step_i = 1'b1; tick(); step_i = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (reg_a_o !== 8'h02) begin n_fail++; $display("FAIL step_one got a=%h required 02", reg_a_o); end
    step_i = 1'b1;
    reset_pulse();
  endtask
`endif

  initial begin
`ifdef CPU_SINGLE_STEP_EN
    step_i = 1'b1;
`endif
    test_reset();
    test_program();
    test_alu_wrap();
    test_jump_wrap();
    test_reset_mid_write();
    test_input_loop();
    test_random();
`ifdef CPU_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
